// File: rtl/momentum_signal_engine.sv
// ============================================================================
// momentum_signal_engine
// ----------------------------------------------------------------------------
// Purpose
//   Multi-stock momentum trade-signal generator. Each stock has its own
//   running average, position state machine (FLAT / LONG / COOL), entry price
//   and post-exit cooldown counter. Every accepted price sample yields exactly
//   one registered decision (buy, sell or hold). The block sits between the
//   price-feed decoder and the order manager.
//
// Ports
//   clk             in   1            clock, all logic on the rising edge
//   rst             in   1            synchronous, active-high reset
//   in_valid_i      in   1            sample valid
//   in_ready_o      out  1            !out_valid_o || out_ready_i
//   in_price_i      in   PRICE_W      sample price (unsigned)
//   in_stock_id_i   in   ID_W         sample stock index
//   out_valid_o     out  1            decision valid, held until out_ready_i
//   out_ready_i     in   1            downstream accepts the decision
//   out_buy_o       out  1            buy decision
//   out_sell_o      out  1            sell decision (never with buy)
//   out_stock_id_o  out  ID_W         echo of the sample stock index
//   out_price_o     out  PRICE_W      echo of the sample price
//   position_o      out  NUM_STOCKS   bit i set while stock i is LONG
//
// Configuration
//   STOP_LOSS_EN    when defined, a LONG stock also sells once the price has
//                   fallen STOP_LOSS or more below its entry price.
// ============================================================================
module momentum_signal_engine #(
    parameter int PRICE_W     = 14,
    parameter int NUM_STOCKS  = 4,
    parameter int ID_W        = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    parameter int EMA_SHIFT   = 1,
    parameter int ENTRY_BAND  = 10,
    parameter int TAKE_PROFIT = 50,
    parameter int COOLDOWN    = 2,
    parameter int STOP_LOSS   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [PRICE_W-1:0]    in_price_i,
    input  logic [ID_W-1:0]       in_stock_id_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_buy_o,
    output logic                  out_sell_o,
    output logic [ID_W-1:0]       out_stock_id_o,
    output logic [PRICE_W-1:0]    out_price_o,
    output logic [NUM_STOCKS-1:0] position_o
);

    // Comparisons run two bits wider than a price so that avg+band and
    // entry+take-profit cannot wrap, and avg-band can go negative.
    localparam int EXT_W = PRICE_W + 2;
    localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic signed [EXT_W-1:0] BAND_X  = EXT_W'(ENTRY_BAND);
    localparam logic signed [EXT_W-1:0] TP_X    = EXT_W'(TAKE_PROFIT);
    localparam logic signed [EXT_W-1:0] PMAX_X  = EXT_W'((2 ** PRICE_W) - 1);
    localparam logic [CNT_W-1:0]        COOL_INIT = CNT_W'(COOLDOWN);
    localparam int unsigned             NUM_STOCKS_U = NUM_STOCKS;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_STOCKS < 1 || NUM_STOCKS > 256) begin : gBadNumStocks
        $error("momentum_signal_engine: NUM_STOCKS must be 1..256");
    end
    if (STOP_LOSS < 0 || COOLDOWN < 0 || ENTRY_BAND < 0 || TAKE_PROFIT < 0) begin : gBadThresholds
        $error("momentum_signal_engine: thresholds must be non-negative");
    end

    typedef enum logic [1:0] {
        ST_FLAT = 2'd0,
        ST_LONG = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    // Per-stock state
    state_t             stateMem_q [NUM_STOCKS];
    logic [PRICE_W-1:0] avgMem_q   [NUM_STOCKS];
    logic [PRICE_W-1:0] entryMem_q [NUM_STOCKS];
    logic [CNT_W-1:0]   coolMem_q  [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] seeded_q;

    // Registered output stage
    logic               outValid_q;
    logic               outBuy_q;
    logic               outSell_q;
    logic [ID_W-1:0]    outStockId_q;
    logic [PRICE_W-1:0] outPrice_q;

    // Selected-stock view and next values
    logic               accept;
    logic               idValid;
    state_t             stateSel;
    logic [PRICE_W-1:0] avgSel;
    logic [PRICE_W-1:0] entrySel;
    logic [CNT_W-1:0]   coolSel;
    logic               seededSel;

    logic signed [EXT_W-1:0] priceX;
    logic signed [EXT_W-1:0] avgX;
    logic signed [EXT_W-1:0] entryX;
    logic signed [EXT_W-1:0] avgPlusBandX;
    logic signed [EXT_W-1:0] avgMinusBandX;
    logic signed [EXT_W-1:0] entryPlusTpX;
    logic signed [PRICE_W:0] diffX;
    logic signed [PRICE_W:0] stepX;
    logic signed [EXT_W-1:0] newAvgX;
    logic [PRICE_W-1:0]      newAvg;
    logic                    exitHit;
    logic                    slHit;

    state_t             state_d;
    logic [PRICE_W-1:0] avg_d;
    logic [PRICE_W-1:0] entry_d;
    logic [CNT_W-1:0]   cool_d;
    logic               seeded_d;
    logic               buy_d;
    logic               sell_d;

    assign in_ready_o = !outValid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign idValid    = (32'(in_stock_id_i) < NUM_STOCKS_U);

    // Read out the addressed stock's state; an out-of-range id sees a neutral
    // view and never writes anything back.
    always_comb begin
        stateSel  = ST_FLAT;
        avgSel    = '0;
        entrySel  = '0;
        coolSel   = '0;
        seededSel = 1'b0;
        if (idValid) begin
            stateSel  = stateMem_q[in_stock_id_i];
            avgSel    = avgMem_q[in_stock_id_i];
            entrySel  = entryMem_q[in_stock_id_i];
            coolSel   = coolMem_q[in_stock_id_i];
            seededSel = seeded_q[in_stock_id_i];
        end
    end

    // Widened thresholds and the running-average step. The step is an
    // arithmetic shift of a signed difference, so the average moves toward
    // the price and stays in range; the clamp only guards the encoding.
    always_comb begin
        priceX        = signed'({2'b00, in_price_i});
        avgX          = signed'({2'b00, avgSel});
        entryX        = signed'({2'b00, entrySel});
        avgPlusBandX  = avgX + BAND_X;
        avgMinusBandX = avgX - BAND_X;
        entryPlusTpX  = entryX + TP_X;
        diffX         = signed'({1'b0, in_price_i}) - signed'({1'b0, avgSel});
        stepX         = diffX >>> EMA_SHIFT;
        newAvgX       = avgX + signed'({stepX[PRICE_W], stepX});
        if (newAvgX < 0) begin
            newAvg = '0;
        end else if (newAvgX > PMAX_X) begin
            newAvg = PMAX_X[PRICE_W-1:0];
        end else begin
            newAvg = newAvgX[PRICE_W-1:0];
        end
    end

`ifdef STOP_LOSS_EN
    localparam logic signed [EXT_W-1:0] SL_X = EXT_W'(STOP_LOSS);
    assign slHit = (priceX < entryX) && ((entryX - priceX) >= SL_X);
`else
    assign slHit = 1'b0;
`endif

    // Take-profit, momentum loss and (optionally) stop-loss share priority.
    // A negative avg-band makes the momentum exit unreachable by construction.
    assign exitHit = (priceX >= entryPlusTpX) || (priceX < avgMinusBandX) || slHit;

    // Decision and next state for the addressed stock, all from pre-update
    // values. The first sample of a stock only seeds its average.
    always_comb begin
        state_d  = stateSel;
        avg_d    = avgSel;
        entry_d  = entrySel;
        cool_d   = coolSel;
        seeded_d = seededSel;
        buy_d    = 1'b0;
        sell_d   = 1'b0;
        if (idValid) begin
            if (!seededSel) begin
                avg_d    = in_price_i;
                seeded_d = 1'b1;
            end else begin
                avg_d = newAvg;
                case (stateSel)
                    ST_FLAT: begin
                        if (priceX > avgPlusBandX) begin
                            buy_d   = 1'b1;
                            entry_d = in_price_i;
                            state_d = ST_LONG;
                        end
                    end
                    ST_LONG: begin
                        if (exitHit) begin
                            sell_d = 1'b1;
                            if (COOLDOWN == 0) begin
                                state_d = ST_FLAT;
                            end else begin
                                state_d = ST_COOL;
                                cool_d  = COOL_INIT;
                            end
                        end
                    end
                    ST_COOL: begin
                        // The sample that drains the counter is still ignored.
                        if (coolSel <= CNT_W'(1)) begin
                            cool_d  = '0;
                            state_d = ST_FLAT;
                        end else begin
                            cool_d = coolSel - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_FLAT;
                    end
                endcase
            end
        end
    end

    // Single state-holding process: per-stock memories and the 1-deep output
    // register. A new accept overwrites the output in the same cycle the old
    // one is taken; otherwise the output is held until out_ready_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q   <= 1'b0;
            outBuy_q     <= 1'b0;
            outSell_q    <= 1'b0;
            outStockId_q <= '0;
            outPrice_q   <= '0;
            seeded_q     <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                stateMem_q[i] <= ST_FLAT;
                avgMem_q[i]   <= '0;
                entryMem_q[i] <= '0;
                coolMem_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                outValid_q   <= 1'b1;
                outBuy_q     <= buy_d;
                outSell_q    <= sell_d;
                outStockId_q <= in_stock_id_i;
                outPrice_q   <= in_price_i;
                if (idValid) begin
                    stateMem_q[in_stock_id_i] <= state_d;
                    avgMem_q[in_stock_id_i]   <= avg_d;
                    entryMem_q[in_stock_id_i] <= entry_d;
                    coolMem_q[in_stock_id_i]  <= cool_d;
                    seeded_q[in_stock_id_i]   <= seeded_d;
                end
            end else if (out_ready_i) begin
                outValid_q <= 1'b0;
            end
        end
    end

    // Position vector follows the LONG state of every stock.
    always_comb begin
        position_o = '0;
        for (int i = 0; i < NUM_STOCKS; i++) begin
            position_o[i] = (stateMem_q[i] == ST_LONG);
        end
    end

    assign out_valid_o    = outValid_q;
    assign out_buy_o      = outBuy_q;
    assign out_sell_o     = outSell_q;
    assign out_stock_id_o = outStockId_q;
    assign out_price_o    = outPrice_q;

endmodule

// File: tb/tb_momentum_signal_engine.sv
// ============================================================================
// tb_momentum_signal_engine
// ----------------------------------------------------------------------------
// Directed scoreboard bench for momentum_signal_engine with default
// parameters. Each applied sample pushes its hand-computed decision into a
// queue; a monitor pops and compares whenever a decision is handed off.
// Expected values follow STOP_LOSS_EN when that macro is defined.
// ============================================================================
module tb_momentum_signal_engine;

    localparam int PRICE_W    = 14;
    localparam int NUM_STOCKS = 4;
    localparam int ID_W       = 2;

`ifdef STOP_LOSS_EN
    localparam bit SL_ON = 1'b1;
`else
    localparam bit SL_ON = 1'b0;
`endif

    typedef struct packed {
        logic               buy;
        logic               sell;
        logic [ID_W-1:0]    id;
        logic [PRICE_W-1:0] price;
    } exp_t;

    logic                  clk;
    logic                  rstTb;
    logic                  inValid;
    logic                  in_ready_o;
    logic [PRICE_W-1:0]    inPrice;
    logic [ID_W-1:0]       inStockId;
    logic                  out_valid_o;
    logic                  outReady;
    logic                  out_buy_o;
    logic                  out_sell_o;
    logic [ID_W-1:0]       out_stock_id_o;
    logic [PRICE_W-1:0]    out_price_o;
    logic [NUM_STOCKS-1:0] position_o;

    exp_t expQ[$];
    int   nChecks;
    int   nFails;
    int   acceptCount;

    momentum_signal_engine dut (
        .clk            (clk),
        .rst            (rstTb),
        .in_valid_i     (inValid),
        .in_ready_o     (in_ready_o),
        .in_price_i     (inPrice),
        .in_stock_id_i  (inStockId),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (outReady),
        .out_buy_o      (out_buy_o),
        .out_sell_o     (out_sell_o),
        .out_stock_id_o (out_stock_id_o),
        .out_price_o    (out_price_o),
        .position_o     (position_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one sample from posedge+1, waits (bounded) for the handshake and
    // returns at posedge+1 of the accepting edge.
    task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [PRICE_W-1:0] price,
                                 input logic expBuy, input logic expSell);
        int  waitCycles;
        bit  done;
        exp_t e;
        e.buy   = expBuy;
        e.sell  = expSell;
        e.id    = id;
        e.price = price;
        expQ.push_back(e);
        inValid   = 1'b1;
        inStockId = id;
        inPrice   = price;
        waitCycles = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready_o) begin
                done = 1'b1;
            end else begin
                waitCycles++;
                if (waitCycles > 50) begin
                    checkOutput("accept_timeout", 32'(in_ready_o), 32'd1);
                    void'(expQ.pop_back());
                    inValid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic checkPos(input string name, input logic [NUM_STOCKS-1:0] expected);
        checkOutput(name, 32'(position_o), 32'(expected));
    endtask

    // Monitor: a decision is handed off at the next rising edge whenever it is
    // valid and ready at the falling edge; compare it against the queue head.
    always @(negedge clk) begin
        if (!rstTb && out_valid_o && outReady) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_output: got id %0d price %0d, expected no decision",
                         out_stock_id_o, out_price_o);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("decision_s%0d_p%0d", e.id, e.price),
                            32'({out_buy_o, out_sell_o, out_stock_id_o, out_price_o}), 32'(e));
                checkOutput("buy_sell_exclusive", 32'(out_buy_o & out_sell_o), 32'd0);
            end
        end
    end

    // Counts handshakes that will occur on the next rising edge.
    always @(negedge clk) begin
        if (!rstTb && inValid && in_ready_o) begin
            acceptCount++;
        end
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        nFails++;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int acceptsBefore;
        int drain;
        nChecks     = 0;
        nFails      = 0;
        acceptCount = 0;
        rstTb       = 1'b1;
        inValid     = 1'b0;
        inPrice     = '0;
        inStockId   = '0;
        outReady    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid_o), 32'd0);
        checkPos("reset_position", 4'b0000);
        rstTb = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready_o), 32'd1);

        // Seed, buy, take-profit sell, cooldown, re-entry on stock 0.
        applyStimulus(2'd0, 14'd1000, 1'b0, 1'b0);
        checkOutput("latency_out_valid", 32'(out_valid_o), 32'd1);
        checkPos("pos_after_seed", 4'b0000);
        applyStimulus(2'd0, 14'd1011, 1'b1, 1'b0);
        checkPos("pos_after_buy", 4'b0001);
        applyStimulus(2'd0, 14'd1061, 1'b0, 1'b1);
        checkPos("pos_after_tp_sell", 4'b0000);
        applyStimulus(2'd0, 14'd1200, 1'b0, 1'b0);
        applyStimulus(2'd0, 14'd1200, 1'b0, 1'b0);
        checkPos("pos_in_cooldown", 4'b0000);
        applyStimulus(2'd0, 14'd1200, 1'b1, 1'b0);
        checkPos("pos_after_rebuy", 4'b0001);

        // Back-pressure: the pending buy must stay frozen while a new sample waits.
        outReady  = 1'b0;
        inValid   = 1'b1;
        inStockId = 2'd0;
        inPrice   = 14'd1205;
        begin
            exp_t e;
            e.buy = 1'b0; e.sell = 1'b0; e.id = 2'd0; e.price = 14'd1205;
            expQ.push_back(e);
        end
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready_o), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid_o), 32'd1);
            checkOutput("stall_out_buy", 32'(out_buy_o), 32'd1);
            checkOutput("stall_out_price", 32'(out_price_o), 32'd1200);
        end
        @(posedge clk);
        #1;
        acceptsBefore = acceptCount;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_single_accept", 32'(acceptCount - acceptsBefore), 32'd1);
        checkPos("pos_after_stall", 4'b0001);

        // Full-scale prices on stock 2: no wrap in average, band or take-profit.
        applyStimulus(2'd2, 14'd16383, 1'b0, 1'b0);
        applyStimulus(2'd2, 14'd16383, 1'b0, 1'b0);
        applyStimulus(2'd2, 14'd0,     1'b0, 1'b0);
        applyStimulus(2'd2, 14'd16383, 1'b1, 1'b0);
        checkPos("pos_full_scale_buy", 4'b0101);
        applyStimulus(2'd2, 14'd16383, 1'b0, 1'b0);

        // Reset while a decision is stalled: it must be dropped.
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre_reset_held_valid", 32'(out_valid_o), 32'd1);
        rstTb = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_stall_valid", 32'(out_valid_o), 32'd0);
        checkPos("reset_mid_stall_position", 4'b0000);
        expQ.delete();
        rstTb    = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;

        // Interleaved stocks, band boundaries and exits.
        applyStimulus(2'd1, 14'd500,  1'b0, 1'b0);
        applyStimulus(2'd3, 14'd2400, 1'b0, 1'b0);
        applyStimulus(2'd1, 14'd520,  1'b1, 1'b0);
        checkPos("pos_interleave_buy", 4'b0010);
        applyStimulus(2'd3, 14'd2410, 1'b0, 1'b0);
        applyStimulus(2'd3, 14'd2416, 1'b1, 1'b0);
        checkPos("pos_band_edge_buy", 4'b1010);
        applyStimulus(2'd0, 14'd1000, 1'b0, 1'b0);
        applyStimulus(2'd0, 14'd1011, 1'b1, 1'b0);
        checkPos("pos_stock0_long", 4'b1011);
        applyStimulus(2'd0, 14'd1006, 1'b0, SL_ON);
        checkPos("pos_stop_loss_edge", SL_ON ? 4'b1010 : 4'b1011);
        applyStimulus(2'd1, 14'd500,  1'b0, SL_ON);
        checkPos("pos_momentum_edge", SL_ON ? 4'b1000 : 4'b1011);
        applyStimulus(2'd1, 14'd494,  1'b0, !SL_ON);
        checkPos("pos_momentum_exit", SL_ON ? 4'b1000 : 4'b1001);
        applyStimulus(2'd1, 14'd600,  1'b0, 1'b0);
        applyStimulus(2'd2, 14'd5,    1'b0, 1'b0);
        applyStimulus(2'd2, 14'd16,   1'b1, 1'b0);
        checkPos("pos_low_avg_buy", SL_ON ? 4'b1100 : 4'b1101);
        applyStimulus(2'd2, 14'd0,    1'b0, SL_ON);
        applyStimulus(2'd2, 14'd0,    1'b0, 1'b0);
        checkPos("pos_final", SL_ON ? 4'b1000 : 4'b1101);

        // Let the scoreboard drain, then the output must go idle.
        drain = 0;
        while (expQ.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        checkOutput("idle_out_valid", 32'(out_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
